// File: rtl/branch_predictor.sv
// Microbranch direction predictor: 2-bit counter table plus an in-flight
// queue of predictions awaiting the checker's verdict.
module branch_predictor #(
    parameter int DEPTH    = 4,
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_req,
    input  logic [10:0] pred_pc,
    input  logic [10:0] pred_target,
    input  logic [10:0] pred_fallthru,
    input  logic [1:0]  pred_type_in,
    output logic        pred_taken,
    output logic        pred_ready,
    input  logic        resolve,
    input  logic        incorrect_pred,
    input  logic        correct_pred,
    input  logic        pop,
    output logic        last_pred,
    output logic [1:0]  pred_type,
    output logic        head_valid,
    output logic        redirect,
    output logic [10:0] redirect_addr,
    output logic [2:0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int N = 1 << IDX_BITS;
    localparam logic [2:0] FULL = 3'(DEPTH);

    logic [1:0]          ctr    [N];
    logic                q_tk   [DEPTH];
    logic [1:0]          q_ty   [DEPTH];
    logic [IDX_BITS-1:0] q_idx  [DEPTH];
    logic [10:0]         q_addr [DEPTH];

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] h_idx;
    logic [1:0]          h_ctr;
    logic                res_ev;
    logic                mis;
    logic                ok;
    logic                push;

    assign idx        = pred_pc[IDX_BITS-1:0];
    assign pred_taken = ctr[idx][1];
    assign head_valid = (count != 3'd0);

    assign res_ev = resolve & head_valid;
    assign mis    = res_ev & incorrect_pred;
    assign ok     = res_ev & pop & ~incorrect_pred;

    assign pred_ready = (count < FULL) | ok;
    // Wrong-path fetches arriving with a flush are dropped
    assign push       = pred_req & pred_ready & ~mis;

    assign h_idx     = q_idx[rd_ptr];
    assign h_ctr     = ctr[h_idx];
    assign last_pred = head_valid & q_tk[rd_ptr];
    assign pred_type = head_valid ? q_ty[rd_ptr] : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (res_ev) begin
            if (correct_pred && h_ctr != 2'b11) begin
                ctr[h_idx] <= h_ctr + 2'b01;
            end else if (!correct_pred && h_ctr != 2'b00) begin
                ctr[h_idx] <= h_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_tk[wr_ptr]   <= pred_taken;
            q_ty[wr_ptr]   <= pred_type_in;
            q_idx[wr_ptr]  <= idx;
            q_addr[wr_ptr] <= pred_taken ? pred_fallthru : pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 3'd0;
        end else if (mis) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + {2'b00, push} - {2'b00, ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect      <= 1'b0;
            redirect_addr <= 11'd0;
        end else begin
            redirect <= mis;
            if (mis) begin
                redirect_addr <= q_addr[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus random stimulus for branch_predictor, checked against a
// queue-and-array model of the prediction rules.
`timescale 1ns/1ps
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_req = 1'b0;
    logic [10:0] pred_pc = '0;
    logic [10:0] pred_target = '0;
    logic [10:0] pred_fallthru = '0;
    logic [1:0]  pred_type_in = '0;
    logic        pred_taken;
    logic        pred_ready;
    logic        resolve = 1'b0;
    logic        incorrect_pred = 1'b0;
    logic        correct_pred = 1'b0;
    logic        pop = 1'b0;
    logic        last_pred;
    logic [1:0]  pred_type;
    logic        head_valid;
    logic        redirect;
    logic [10:0] redirect_addr;
    logic [2:0]  count;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_target(pred_target), .pred_fallthru(pred_fallthru),
        .pred_type_in(pred_type_in), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .resolve(resolve),
        .incorrect_pred(incorrect_pred), .correct_pred(correct_pred),
        .pop(pop), .last_pred(last_pred), .pred_type(pred_type),
        .head_valid(head_valid), .redirect(redirect),
        .redirect_addr(redirect_addr), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit        tk;
        bit [1:0]  ty;
        int        idx;
        bit [10:0] addr;
    } ent_t;

    ent_t      q[$];
    int        ctr[16];
    bit        m_redir;
    bit [10:0] m_raddr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (ctr[i]) ctr[i] = 1;
        m_redir = 0;
        m_raddr = '0;
    endtask

    task automatic chk_state(string w);
        chk({w, "_count"}, count, q.size());
        chk({w, "_head_valid"}, head_valid, q.size() > 0);
        chk({w, "_last_pred"}, last_pred, q.size() > 0 ? q[0].tk : 1'b0);
        chk({w, "_pred_type"}, pred_type, q.size() > 0 ? q[0].ty : 2'b00);
        chk({w, "_redirect"}, redirect, m_redir);
        chk({w, "_redirect_addr"}, redirect_addr, m_raddr);
    endtask

    // One clock: drive, check combinational outputs, clock, update model, check state
    task automatic cyc(bit rq, bit [10:0] pc, bit [10:0] tg, bit [10:0] ft,
                       bit [1:0] ty, bit rs, bit inc, bit cp, bit pp);
        bit   tk, rev, misp, good, rdy, acc;
        int   ix;
        ent_t h;
        pred_req = rq; pred_pc = pc; pred_target = tg;
        pred_fallthru = ft; pred_type_in = ty;
        resolve = rs; incorrect_pred = inc; correct_pred = cp; pop = pp;
        ix   = int'(pc) % 16;
        tk   = ctr[ix] >= 2;
        rev  = rs && q.size() > 0;
        misp = rev && inc;
        good = rev && pp && !inc;
        rdy  = q.size() < 4 || good;
        acc  = rq && rdy && !misp;
        #1;
        chk("pred_taken", pred_taken, tk);
        chk("pred_ready", pred_ready, rdy);
        chk_state("pre");
        @(posedge clk);
        m_redir = 0;
        if (rev) begin
            h = q[0];
            if (cp) ctr[h.idx] = (ctr[h.idx] == 3) ? 3 : ctr[h.idx] + 1;
            else    ctr[h.idx] = (ctr[h.idx] == 0) ? 0 : ctr[h.idx] - 1;
            if (misp) begin
                m_redir = 1;
                m_raddr = h.addr;
                q.delete();
            end else if (good) begin
                void'(q.pop_front());
            end
        end
        if (acc) q.push_back('{tk, ty, ix, tk ? ft : tg});
        #1;
        chk_state("post");
        pred_req = 0; resolve = 0; incorrect_pred = 0; pop = 0;
    endtask

    task automatic push(bit [10:0] pc, bit [10:0] tg, bit [10:0] ft, bit [1:0] ty);
        cyc(1, pc, tg, ft, ty, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 11'd0, 11'd0, 11'd0, 2'b01, 0, 0, 0, 0);
    endtask

    // Checker verdict derived from the model's head prediction
    task automatic res(bit cp);
        bit inc;
        inc = q.size() > 0 ? (q[0].tk != cp) : 1'b0;
        cyc(0, 11'd0, 11'd0, 11'd0, 2'b01, 1, inc, cp, !inc);
    endtask

    initial begin
        bit        rq, rs, inc, cp, pp;
        bit [10:0] pc;
        model_reset();
        #2;
        chk_state("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            cyc(0, 11'(i), 11'd0, 11'd0, 2'b01, 0, 0, 0, 0);
        end

        push(11'h005, 11'h040, 11'h006, 2'b01);
        chk("r40_count", count, 1);
        chk("r40_last_pred", last_pred, 0);
        chk("r40_pred_type", pred_type, 2'b01);

        res(1);
        chk("r41_redirect", redirect, 1);
        chk("r41_redirect_addr", redirect_addr, 11'h040);
        chk("r41_count", count, 0);
        idle();
        chk("r41_redirect_gone", redirect, 0);
        chk("r41_addr_hold", redirect_addr, 11'h040);
        push(11'h005, 11'h040, 11'h006, 2'b10);
        chk("r41_taken", last_pred, 1);
        res(1);
        push(11'h005, 11'h040, 11'h006, 2'b10);
        res(1);

        for (int i = 0; i < 4; i++) push(11'(8 + i), 11'h100, 11'h009, 2'b11);
        chk("r42_ready", pred_ready, 0);
        push(11'h00c, 11'h100, 11'h00d, 2'b01);
        chk("r42_count_full", count, 4);
        cyc(1, 11'h00d, 11'h120, 11'h00e, 2'b10, 1, 0, 0, 1);
        chk("r42_count_keep", count, 4);

        res(1);
        idle();
        for (int i = 0; i < 3; i++) push(11'(0 + i), 11'h200, 11'h001, 2'b01);
        cyc(1, 11'h007, 11'h300, 11'h008, 2'b10, 1, 1, 1, 0);
        chk("r43_count", count, 0);
        chk("r43_redirect", redirect, 1);
        idle();
        chk("r43_once", redirect, 0);

        for (int i = 0; i < 4; i++) begin
            push(11'h003, 11'h030, 11'h004, 2'b01);
            res(1);
        end
        for (int i = 0; i < 5; i++) begin
            push(11'h003, 11'h030, 11'h004, 2'b01);
            res(0);
        end
        idle();

        push(11'h00a, 11'h050, 11'h00b, 2'b01);
        push(11'h00b, 11'h060, 11'h00c, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("r45_count", count, 0);
        chk("r45_head_valid", head_valid, 0);
        chk("r45_redirect", redirect, 0);
        model_reset();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) idle();

        for (int n = 0; n < 400; n++) begin
            rq  = $urandom_range(0, 3) != 0;
            pc  = 11'($urandom_range(0, 31));
            rs  = $urandom_range(0, 2) == 0;
            cp  = 1'($urandom);
            inc = q.size() > 0 ? (q[0].tk != cp) : 1'($urandom);
            pp  = inc ? 1'($urandom) : 1'b1;
            cyc(rq, pc, 11'($urandom), 11'($urandom),
                2'($urandom_range(1, 3)), rs, inc, cp, pp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter DEPTH, default 4: number of in-flight prediction queue entries, power of two.
REQ-002 Parameter IDX_BITS, default 4: counter table index width; the table has 2^IDX_BITS entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pred_req  input  1  fetch presents a conditional-branch microinstruction this cycle.
REQ-006 pred_pc  input  11  microaddress of the branch (P).
REQ-007 pred_target  input  11  branch target microaddress.
REQ-008 pred_fallthru  input  11  sequential microaddress.
REQ-009 pred_type_in  input  2  branch type: 01 JZE, 10 JNE, 11 JCY; 00 is illegal.
REQ-010 pred_taken  output  1  combinational predicted direction for the current pred_pc.
REQ-011 pred_ready  output  1  queue not full; push accepted only when high.
REQ-012 resolve  input  1  checker result valid this cycle.
REQ-013 incorrect_pred  input  1  checker: head prediction was wrong.
REQ-014 correct_pred  input  1  checker: actual branch direction (1 = taken).
REQ-015 pop  input  1  checker: head prediction was right, retire it.
REQ-016 last_pred  output  1  predicted direction of the head entry (0 when empty).
REQ-017 pred_type  output  2  type of the head entry (00 when empty).
REQ-018 head_valid  output  1  queue non-empty.
REQ-019 redirect  output  1  registered one-cycle mispredict pulse.
REQ-020 redirect_addr  output  11  registered recovery microaddress; valid while redirect=1.
REQ-021 count  output  3  occupied entries, 0..DEPTH.

Function
REQ-022 The counter table SHALL hold one 2-bit saturating counter per index, indexed by pred_pc[IDX_BITS-1:0].
REQ-023 pred_taken SHALL be the MSB of the indexed counter.
REQ-024 A push occurs when pred_req=1 and pred_ready=1.
REQ-025 Each push SHALL store {pred_taken, pred_type_in, index, recovery address}.
- Recovery address = pred_fallthru if predicted taken, else pred_target.
REQ-026 pred_req with pred_ready=0 SHALL be ignored with no state change; fetch is responsible for stalling.
REQ-027 A resolve event occurs when resolve=1 and head_valid=1; resolve while empty SHALL be ignored.
REQ-028 On each resolve event the head entry's counter SHALL move toward correct_pred.
- Taken: increment, saturating at 11.
- Not taken: decrement, saturating at 00.
REQ-029 On resolve with pop=1 and incorrect_pred=0, the head SHALL retire; the read pointer advances mod DEPTH.
REQ-030 On resolve with incorrect_pred=1, the following SHALL all happen:
- The whole queue is flushed (count=0, pointers equal).
- redirect=1 for exactly the next cycle.
- redirect_addr = head recovery address.
REQ-031 A push and a correct resolve in the same cycle SHALL both take effect, leaving count unchanged; this is legal even when full.
REQ-032 A push in the same cycle as a mispredict resolve SHALL be discarded (wrong path); the flush wins.
REQ-033 When a push and a counter update hit the same index in one cycle, the push SHALL use the pre-update counter value.
REQ-034 pred_ready SHALL be (count < DEPTH) or (a correct resolve this cycle).
REQ-035 redirect_addr SHALL hold its value when redirect=0.
REQ-036 If incorrect_pred=1 and pop=1 arrive together, incorrect_pred SHALL take precedence.

Reset
REQ-037 rst_n=0 SHALL immediately set the following, regardless of clk:
- All counters to 01 (weakly not-taken).
- Pointers and count to 0; head_valid=0.
- redirect=0 and redirect_addr=0.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight entries; no redirect is produced after release.
REQ-039 After release, pred_taken SHALL read 0 for every index until the first counter update.

Verification
REQ-040 Reset, then push pc=0x005, target 0x040, fallthru 0x006 -> pred_taken=0, count=1, last_pred=0, pred_type=type pushed.
REQ-041 Resolve twice with correct_pred=1 on index 5, re-pushing between -> first mispredict gives redirect=1, redirect_addr=0x040 next cycle, count=0; counter 01->10->11; next push of pc 0x005 predicts taken.
REQ-042 Push 4 entries -> pred_ready=0, a 5th pred_req is ignored, count=4; a push plus correct resolve in the same cycle keeps count=4 and the head advances.
REQ-043 Three entries queued, head mispredicted with a simultaneous push -> count=0, the pushed entry is dropped, redirect pulses once for one cycle.
REQ-044 Counter at 11 resolved taken -> stays 11; counter at 00 resolved not-taken -> stays 00.
REQ-045 Assert rst_n=0 with two entries queued between clock edges -> count=0 and head_valid=0 immediately; no redirect after release.
